// File: rtl/rect_drawer_pkg.sv
// Shared definitions for the rectangle fill engine: screen size defaults,
// coordinate/colour widths, FSM state encoding and the edge-clipping helper.
package rect_drawer_pkg;

  localparam int X_MAX_DEFAULT = 160;
  localparam int Y_MAX_DEFAULT = 120;

  localparam int X_W     = 8;
  localparam int Y_W     = 7;
  localparam int COLOR_W = 3;

  // Extents and sums are carried 9 bits wide so x0+width (max 510) never wraps.
  localparam int EXT_W = 9;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAW   = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  // Number of pixels from pos up to min(pos+len, limit); zero when pos is
  // already off-screen. Inputs are zero-extended coordinates/lengths (<=255),
  // so the 9-bit sum cannot overflow.
  function automatic logic [EXT_W-1:0] clip_extent(
    input logic [EXT_W-1:0] pos,
    input logic [EXT_W-1:0] len,
    input logic [EXT_W-1:0] limit
  );
    logic [EXT_W-1:0] end_pos;
    end_pos = pos + len;
    if (pos >= limit) begin
      clip_extent = 9'd0;
    end else if (end_pos > limit) begin
      clip_extent = limit - pos;
    end else begin
      clip_extent = len;
    end
  endfunction

endpackage

// File: rtl/rect_drawer.sv
// Filled-rectangle engine. A start request in IDLE is clipped against the
// screen, then DRAW walks the rectangle in row-major order emitting one
// image-RAM write per cycle; FINISH pulses done and returns to IDLE.
// All outputs are registers that feed the RAM write port directly.
module rect_drawer
  import rect_drawer_pkg::*;
#(
  parameter int X_MAX = X_MAX_DEFAULT,
  parameter int Y_MAX = Y_MAX_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [X_W-1:0]     x0,
  input  logic [Y_W-1:0]     y0,
  input  logic [X_W-1:0]     width,
  input  logic [Y_W-1:0]     height,
  input  logic [COLOR_W-1:0] color,
  output logic [X_W-1:0]     x_write,
  output logic [Y_W-1:0]     y_write,
  output logic [COLOR_W-1:0] color_in,
  output logic               wren,
  output logic               busy,
  output logic               done
);

  localparam logic [EXT_W-1:0] X_LIMIT = EXT_W'(X_MAX);
  localparam logic [EXT_W-1:0] Y_LIMIT = EXT_W'(Y_MAX);

  state_t state;

  // Request geometry latched at start; inputs are free to change afterwards.
  logic [X_W-1:0] x_left;
  logic [X_W-1:0] x_last;
  logic [Y_W-1:0] y_last;

  // Clipped view of the incoming request.
  logic [EXT_W-1:0] clip_w;
  logic [EXT_W-1:0] clip_h;
  logic [EXT_W-1:0] x_last_ext;
  logic [EXT_W-1:0] y_last_ext;
  logic             empty_rect;

  // Position of the current pixel within the rectangle.
  logic row_end;
  logic last_pixel;

  // Clip the incoming request against the right and bottom screen edges.
  always_comb begin
    clip_w     = clip_extent({1'b0, x0}, {1'b0, width}, X_LIMIT);
    clip_h     = clip_extent({2'b00, y0}, {2'b00, height}, Y_LIMIT);
    empty_rect = (clip_w == 9'd0) || (clip_h == 9'd0);
    // Only meaningful when the rectangle is non-empty; then both fit on screen.
    x_last_ext = {1'b0, x0} + clip_w - 9'd1;
    y_last_ext = {2'b00, y0} + clip_h - 9'd1;
  end

  // Detect end of the current row and end of the whole rectangle.
  always_comb begin
    row_end    = (x_write == x_last);
    last_pixel = row_end && (y_write == y_last);
  end

  // Control FSM driving the registered RAM write port and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      x_write  <= '0;
      y_write  <= '0;
      color_in <= '0;
      wren     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      x_left   <= '0;
      x_last   <= '0;
      y_last   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy   <= 1'b1;
            x_left <= x0;
            x_last <= x_last_ext[X_W-1:0];
            y_last <= y_last_ext[Y_W-1:0];
            if (empty_rect) begin
              // Nothing visible: skip straight to the done pulse, leaving the
              // write-port address/data at their previous values.
              state <= ST_FINISH;
              wren  <= 1'b0;
              done  <= 1'b1;
            end else begin
              // First pixel is presented in the very next cycle.
              state    <= ST_DRAW;
              wren     <= 1'b1;
              x_write  <= x0;
              y_write  <= y0;
              color_in <= color;
            end
          end else begin
            wren <= 1'b0;
            busy <= 1'b0;
          end
        end

        ST_DRAW: begin
          if (last_pixel) begin
            // Hold the final address/data; only the strobe drops.
            state <= ST_FINISH;
            wren  <= 1'b0;
            done  <= 1'b1;
          end else if (row_end) begin
            x_write <= x_left;
            y_write <= y_write + Y_W'(1);
          end else begin
            x_write <= x_write + X_W'(1);
          end
        end

        ST_FINISH: begin
          state <= ST_IDLE;
          wren  <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end

        default: begin
          state <= ST_IDLE;
          wren  <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rect_drawer.sv
// Scoreboard bench for rect_drawer. The driver feeds a reference model that
// expands each accepted request into the list of pixel writes plus a done
// marker, each tagged with the cycle it must appear in; a monitor process
// pops and compares whenever the DUT shows wren or done.
module tb_rect_drawer;

  localparam int X_MAX = 160;
  localparam int Y_MAX = 120;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] x0 = 8'd0;
  logic [6:0] y0 = 7'd0;
  logic [7:0] width = 8'd0;
  logic [6:0] height = 7'd0;
  logic [2:0] color = 3'd0;
  logic [7:0] x_write;
  logic [6:0] y_write;
  logic [2:0] color_in;
  logic       wren;
  logic       busy;
  logic       done;

  rect_drawer #(.X_MAX(X_MAX), .Y_MAX(Y_MAX)) dut (
    .clk(clk), .reset(reset), .start(start),
    .x0(x0), .y0(y0), .width(width), .height(height), .color(color),
    .x_write(x_write), .y_write(y_write), .color_in(color_in),
    .wren(wren), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit is_write;
    int x;
    int y;
    int c;
    int cyc;
  } ev_t;

  ev_t q[$];
  int  checks = 0;
  int  errors = 0;
  int  free_cyc = 0;   // first cycle in which the model says a start is accepted

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: which pixels a request paints and when.
  task automatic model_accept(input int ax, input int ay, input int aw, input int ah, input int ac);
    int  cw, ch, k;
    ev_t e;
    cw = (ax >= X_MAX) ? 0 : ((ax + aw > X_MAX) ? X_MAX - ax : aw);
    ch = (ay >= Y_MAX) ? 0 : ((ay + ah > Y_MAX) ? Y_MAX - ay : ah);
    k = 0;
    if (cw > 0 && ch > 0) begin
      for (int yy = ay; yy < ay + ch; yy++) begin
        for (int xx = ax; xx < ax + cw; xx++) begin
          e.is_write = 1'b1; e.x = xx; e.y = yy; e.c = ac; e.cyc = cyc + 1 + k;
          q.push_back(e);
          k++;
        end
      end
    end
    e.is_write = 1'b0; e.x = 0; e.y = 0; e.c = 0; e.cyc = cyc + 1 + k;
    q.push_back(e);
    free_cyc = cyc + k + 2;
  endtask

  // Drive one cycle of inputs; the model decides whether start is taken.
  task automatic issue(input int ax, input int ay, input int aw, input int ah, input int ac, input bit st);
    x0 = 8'(ax); y0 = 7'(ay); width = 8'(aw); height = 7'(ah); color = 3'(ac);
    start = st;
    if (st && cyc >= free_cyc) model_accept(ax, ay, aw, ah, ac);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_free();
    int guard;
    guard = 0;
    while (cyc < free_cyc && guard < 30000) begin
      tick();
      guard++;
    end
    check("wait_free_timeout", int'(cyc >= free_cyc), 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    tick();
    reset = 1'b0;
    q.delete();
    free_cyc = cyc;
    @(negedge clk);
    check("rst_wren", int'(wren), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_x_write", int'(x_write), 0);
    check("rst_y_write", int'(y_write), 0);
    check("rst_color_in", int'(color_in), 0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every DUT write/done against the scoreboard.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc < cyc) begin
        check(q[0].is_write ? "missing_write" : "missing_done", 0, 1);
        void'(q.pop_front());
      end
      if (wren === 1'b1 || done === 1'b1) begin
        if (q.size() == 0 || q[0].cyc != cyc) begin
          check("unexpected_output", 1, 0);
        end else begin
          e = q.pop_front();
          check("wren", int'(wren), int'(e.is_write));
          check("done", int'(done), int'(!e.is_write));
          check("busy_active", int'(busy), 1);
          if (e.is_write) begin
            check("x_write", int'(x_write), e.x);
            check("y_write", int'(y_write), e.y);
            check("color_in", int'(color_in), e.c);
          end
        end
      end
      if (wren === 1'b1) begin
        check("write_on_screen", int'(int'(x_write) < X_MAX && int'(y_write) < Y_MAX), 1);
      end
    end
  end

  // Stimulus: directed corner cases, random traffic, then a full-screen fill.
  initial begin
    int ax, ay, aw, ah, ac;
    bit st;

    do_reset();

    // 2x2 at (10,20) colour 5, then a back-to-back request at the first free cycle.
    issue(10, 20, 2, 2, 5, 1'b1);
    wait_free();
    issue(3, 4, 3, 1, 6, 1'b1);

    // Right-edge clip: only columns 158 and 159.
    wait_free();
    issue(158, 0, 4, 1, 3, 1'b1);

    // Bottom-edge clip.
    wait_free();
    issue(10, 118, 2, 5, 2, 1'b1);

    // Zero extents: zero width, and fully off-screen x0.
    wait_free();
    issue(5, 5, 0, 3, 1, 1'b1);
    wait_free();
    issue(200, 5, 5, 2, 7, 1'b1);
    wait_free();
    issue(5, 5, 3, 0, 4, 1'b1);

    // Second start during a 4x1 draw is ignored; inputs wander while busy.
    wait_free();
    issue(20, 30, 4, 1, 6, 1'b1);
    issue(40, 50, 7, 7, 1, 1'b1);
    issue(90, 60, 9, 3, 2, 1'b0);

    // Reset in cycle 3 of a 10x10 draw: no done, then a normal draw.
    wait_free();
    issue(50, 50, 10, 10, 4, 1'b1);
    tick();
    tick();
    do_reset();
    issue(60, 70, 3, 2, 5, 1'b1);

    // Random traffic; inputs change every cycle, starts land anywhere.
    for (int i = 0; i < 600; i++) begin
      if ($urandom % 4 == 0) begin
        ax = 150 + int'($urandom % 106);
        aw = int'($urandom % 256);
      end else begin
        ax = int'($urandom % 150);
        aw = int'($urandom % 9);
      end
      if ($urandom % 4 == 0) begin
        ay = 110 + int'($urandom % 18);
        ah = int'($urandom % 128);
      end else begin
        ay = int'($urandom % 110);
        ah = int'($urandom % 6);
      end
      ac = int'($urandom % 8);
      st = ($urandom % 3 == 0);
      issue(ax, ay, aw, ah, ac, st);
    end

    // Full-screen fill.
    wait_free();
    issue(0, 0, 160, 120, 7, 1'b1);
    wait_free();
    tick();
    tick();
    tick();
    check("scoreboard_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
